qsys_led_pwm_fader: RTL
=======================

// Module: qsys_led_pwm_fader
// PURPOSE
//  Parametrised N-channel PWM LED driver; successor to the fixed 3-channel RGB function block.
//  Per-channel targets come from Avalon-MM registers or one Avalon-ST beat carrying all channels.
//  Adds linear fade (ramp current level toward target at a programmable rate).
//  Adds glitch-free duty update: new duty latched only at PWM period wrap.
//  Sits on the Qsys MM interconnect; LED pins go straight to board I/O.
// PARAMETERS
//  CH          3   channel count, 1..6
//  PWM_W       8   PWM counter/duty width, 1..16; period = 2^PWM_W clocks
//  ACTIVE_LOW  1   1: pin driven 0 = LED on; 0: pin driven 1 = LED on
// PORTS
//  csi_MCLK_clk          in   1           single clock; all logic on rising edge
//  rsi_MRST_reset        in   1           asynchronous, active-high reset
//  avs_LEDD_address      in   4           word address
//  avs_LEDD_writedata    in   32          MM write data
//  avs_LEDD_readdata     out  32          MM read data, combinational, zero-latency
//  avs_LEDD_byteenable   in   4           MM byte lanes
//  avs_LEDD_write        in   1           MM write strobe
//  avs_LEDD_read         in   1           MM read strobe
//  avs_LEDD_waitrequest  out  1           = rsi_MRST_reset
//  asi_LEDS_data         in   CH*PWM_W    ST targets; channel 0 in MSBs
//  asi_LEDS_valid        in   1           ST valid
//  asi_LEDS_ready        out  1           = st_en
//  coe_LED               out  CH          PWM pins, registered
// BEHAVIOUR
//  Register map; unused addresses read 0, writes ignored:
//   0 CTRL RW  [31] st_en, [30] fade_en (byte lane 3); [15:0] fade_div (lanes 1:0)
//   1 STAT RO  [CH-1:0] busy_i = (current_i != target_i)
//   2+i TARGET_i RW  [PWM_W-1:0]; written per enabled byte lane
//   8+i LEVEL_i RO  current_i, the fading level
//  Reset values: CTRL = 0; all target/current/applied levels = 0; PWM counter = 0;
//   tick counter = 0; coe_LED = all-ones when ACTIVE_LOW, else all-zeros.
//  Target sources:
//   - st_en=1: each valid beat loads every target_i in 1 cycle; MM TARGET writes dropped.
//   - st_en=0: MM TARGET writes apply; ST data ignored, ready=0.
//   - Same-cycle CTRL write clearing st_en and valid beat: beat still accepted
//     (ready was 1 that cycle).
//  Fade:
//   - fade_en=0: current_i <= target_i on the next clock.
//   - fade_en=1: tick fires when tick_cnt == fade_div; tick_cnt then returns to 0.
//   - fade_div=0 gives a tick every cycle.
//   - On each tick, every current_i moves 1 LSB toward target_i; no overshoot, no wrap.
//   - Any write to CTRL byte lanes 1:0 clears tick_cnt.
//   - Target change mid-fade: ramp continues from present current_i toward the new target.
//  PWM:
//   - Shared free-running PWM_W counter; wraps from all-ones to 0.
//   - applied_i <= current_i only in the cycle the counter is all-ones.
//   - on_i = (pwm_cnt < applied_i); coe_LED[i] <= on_i ^ ACTIVE_LOW; 1-cycle pipeline.
//   - Duty 0: never on. Duty 2^PWM_W-1: on for 2^PWM_W-1 of each 2^PWM_W clocks.
//  Reset asserted mid-operation returns everything to the reset values immediately.
//   Pins go to the off level asynchronously.
// STRUCTURE
//  Package qsys_led_pkg: register addresses (ADDR_CTRL/STAT/TARGET0/LEVEL0),
//   CTRL bit positions (ST_EN_BIT=31, FADE_EN_BIT=30, FADE_DIV_MSB=15).
//  Sub-module qsys_led_pwm_channel holds target/current/applied regs, the step logic and the comparator.
//   Generated CH times.
//  Top holds CTRL, tick generator, PWM counter, MM decode/readmux and ST fan-out.
// TESTING
//  1. Reset, ACTIVE_LOW=1 -> coe_LED=3'b111; CTRL reads 0; waitrequest high during reset, low after.
//  2. MM TARGET0=0x40, fade_en=0 -> after the next wrap, LED0 low 64 of every 256 clocks.
//     TARGET1=0 -> LED1 never low.
//  3. fade_en=1, fade_div=3, TARGET2 0x00->0x10 -> LEVEL2 +1 every 4 clocks.
//     Reaches 0x10 after 64 clocks; STAT[2] then clears.
//  4. Change TARGET0 mid-period -> duty changes only at the counter wrap; no short or extra pulse.
//  5. st_en=1, beat 0xFF8001 -> targets 0xFF/0x80/0x01, ready=1.
//     Same-cycle MM TARGET0=0x22 is dropped.
//  6. Reset asserted mid-fade at LEVEL0=0x20 -> pins go off level asynchronously; all levels read 0 after release.

Source files
------------

// File: rtl/qsys_led_pkg.sv
// Shared register map and CTRL field positions for the LED PWM fader.
package qsys_led_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_STAT    = 4'd1;
  localparam logic [3:0] ADDR_TARGET0 = 4'd2;
  localparam logic [3:0] ADDR_LEVEL0  = 4'd8;

  localparam int ST_EN_BIT    = 31;
  localparam int FADE_EN_BIT  = 30;
  localparam int FADE_DIV_MSB = 15;

endpackage

// File: rtl/qsys_led_pwm_channel.sv
// One LED channel: target/current/applied levels, fade step and PWM compare.
module qsys_led_pwm_channel
  import qsys_led_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mm_we_i,
  input  logic [31:0]      mm_wdata_i,
  input  logic [3:0]       mm_be_i,
  input  logic             st_we_i,
  input  logic [PWM_W-1:0] st_data_i,
  input  logic             fade_en_i,
  input  logic             tick_i,
  input  logic             wrap_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  output logic [PWM_W-1:0] target_o,
  output logic [PWM_W-1:0] current_o,
  output logic             busy_o,
  output logic             led_o
);

  logic [PWM_W-1:0] target_q, target_d;
  logic [PWM_W-1:0] current_q, current_d;
  logic [PWM_W-1:0] applied_q, applied_d;
  logic             led_q, led_d;

  // Next-state: ST beat has priority; MM writes merge per enabled byte lane.
  always_comb begin
    target_d = target_q;
    if (st_we_i) begin
      target_d = st_data_i;
    end else if (mm_we_i) begin
      for (int b = 0; b < PWM_W; b++) begin
        if (mm_be_i[b / 8]) target_d[b] = mm_wdata_i[b];
      end
    end

    // Without fading the level snaps to the target; with fading it steps one LSB per tick.
    current_d = current_q;
    if (!fade_en_i) begin
      current_d = target_q;
    end else if (tick_i) begin
      if (current_q < target_q)      current_d = current_q + 1'b1;
      else if (current_q > target_q) current_d = current_q - 1'b1;
    end

    // Duty is only picked up on the last count of a period so pulses never get truncated.
    applied_d = wrap_i ? current_q : applied_q;
    led_d     = (pwm_cnt_i < applied_q) ^ ACTIVE_LOW;
  end

  // Channel state; reset drives the pin to its off level immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      target_q  <= '0;
      current_q <= '0;
      applied_q <= '0;
      led_q     <= ACTIVE_LOW;
    end else begin
      target_q  <= target_d;
      current_q <= current_d;
      applied_q <= applied_d;
      led_q     <= led_d;
    end
  end

  assign target_o  = target_q;
  assign current_o = current_q;
  assign busy_o    = (current_q != target_q);
  assign led_o     = led_q;

endmodule

// File: rtl/qsys_led_pwm_fader.sv
// N-channel PWM LED driver with fade, Avalon-MM control and Avalon-ST targets.
module qsys_led_pwm_fader
  import qsys_led_pkg::*;
#(
  parameter int CH         = 3,
  parameter int PWM_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  csi_MCLK_clk,
  input  logic                  rsi_MRST_reset,
  input  logic [3:0]            avs_LEDD_address,
  input  logic [31:0]           avs_LEDD_writedata,
  output logic [31:0]           avs_LEDD_readdata,
  input  logic [3:0]            avs_LEDD_byteenable,
  input  logic                  avs_LEDD_write,
  input  logic                  avs_LEDD_read,
  output logic                  avs_LEDD_waitrequest,
  input  logic [CH*PWM_W-1:0]   asi_LEDS_data,
  input  logic                  asi_LEDS_valid,
  output logic                  asi_LEDS_ready,
  output logic [CH-1:0]         coe_LED
);

  logic                   st_en_q, fade_en_q;
  logic [FADE_DIV_MSB:0]  fade_div_q;
  logic [FADE_DIV_MSB:0]  tick_cnt_q, tick_cnt_d;
  logic [PWM_W-1:0]       pwm_cnt_q;
  logic                   ctrl_we, div_we, tick, wrap, st_we;
  logic [PWM_W-1:0]       target_w [CH];
  logic [PWM_W-1:0]       level_w  [CH];
  logic [CH-1:0]          busy_w;

  assign ctrl_we = avs_LEDD_write && (avs_LEDD_address == ADDR_CTRL);
  assign div_we  = ctrl_we && (|avs_LEDD_byteenable[1:0]);
  assign tick    = (tick_cnt_q == fade_div_q);
  assign wrap    = &pwm_cnt_q;
  // Ready is the registered st_en, so a beat arriving with a CTRL write that clears st_en still lands.
  assign st_we   = st_en_q && asi_LEDS_valid;

  assign avs_LEDD_waitrequest = rsi_MRST_reset;
  assign asi_LEDS_ready       = st_en_q;

  // Tick counter restarts on a tick or whenever the divider lanes are written.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (div_we || tick) tick_cnt_d = '0;
  end

  // CTRL register: enables on byte lane 3, fade divider on lanes 1:0.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      st_en_q    <= 1'b0;
      fade_en_q  <= 1'b0;
      fade_div_q <= '0;
    end else if (ctrl_we) begin
      if (avs_LEDD_byteenable[3]) begin
        st_en_q   <= avs_LEDD_writedata[ST_EN_BIT];
        fade_en_q <= avs_LEDD_writedata[FADE_EN_BIT];
      end
      if (avs_LEDD_byteenable[1]) fade_div_q[15:8] <= avs_LEDD_writedata[15:8];
      if (avs_LEDD_byteenable[0]) fade_div_q[7:0]  <= avs_LEDD_writedata[7:0];
    end
  end

  // Fade tick divider and shared free-running PWM counter.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    localparam logic [3:0] TGT_ADDR = ADDR_TARGET0 + 4'(gi);
    logic mm_we;
    assign mm_we = avs_LEDD_write && !st_en_q && (avs_LEDD_address == TGT_ADDR);

    qsys_led_pwm_channel #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk_i      (csi_MCLK_clk),
      .rst_i      (rsi_MRST_reset),
      .mm_we_i    (mm_we),
      .mm_wdata_i (avs_LEDD_writedata),
      .mm_be_i    (avs_LEDD_byteenable),
      .st_we_i    (st_we),
      .st_data_i  (asi_LEDS_data[(CH-1-gi)*PWM_W +: PWM_W]),
      .fade_en_i  (fade_en_q),
      .tick_i     (tick),
      .wrap_i     (wrap),
      .pwm_cnt_i  (pwm_cnt_q),
      .target_o   (target_w[gi]),
      .current_o  (level_w[gi]),
      .busy_o     (busy_w[gi]),
      .led_o      (coe_LED[gi])
    );
  end

  // Zero-latency read mux; unmapped addresses return 0.
  always_comb begin
    avs_LEDD_readdata = '0;
    if (avs_LEDD_read) begin
      if (avs_LEDD_address == ADDR_CTRL) begin
        avs_LEDD_readdata[ST_EN_BIT]        = st_en_q;
        avs_LEDD_readdata[FADE_EN_BIT]      = fade_en_q;
        avs_LEDD_readdata[FADE_DIV_MSB:0]   = fade_div_q;
      end else if (avs_LEDD_address == ADDR_STAT) begin
        avs_LEDD_readdata[CH-1:0] = busy_w;
      end
      for (int i = 0; i < CH; i++) begin
        if (avs_LEDD_address == ADDR_TARGET0 + 4'(i)) avs_LEDD_readdata[PWM_W-1:0] = target_w[i];
        if (avs_LEDD_address == ADDR_LEVEL0 + 4'(i))  avs_LEDD_readdata[PWM_W-1:0] = level_w[i];
      end
    end
  end

endmodule
